// File: rtl/mmio_uart_perf_pkg.sv
// Register map and status bit positions shared by the MMIO UART/perf-counter block.
package mmio_uart_perf_pkg;

  localparam logic [7:0] OFS_STATUS = 8'h00;
  localparam logic [7:0] OFS_RX     = 8'h04;
  localparam logic [7:0] OFS_TX     = 8'h08;
  localparam logic [7:0] OFS_LVL    = 8'h0C;
  localparam logic [7:0] OFS_CYC    = 8'h10;
  localparam logic [7:0] OFS_EVT0   = 8'h14;
  localparam logic [7:0] OFS_CLR    = 8'h18;
  localparam logic [7:0] OFS_EVT1   = 8'h1C;
  localparam logic [7:0] OFS_SNAP   = 8'h3C;

  localparam int ST_TX_READY = 0;
  localparam int ST_RX_VALID = 1;
  localparam int ST_TX_DROP  = 2;
  localparam int ST_TX_EMPTY = 3;
  localparam int ST_RX_FULL  = 4;

  // Counter 0 sits in the legacy slot; the rest follow the clear register.
  function automatic logic [7:0] evt_ofs(input int i);
    return (i == 0) ? OFS_EVT0 : OFS_EVT1 + 8'(4 * (i - 1));
  endfunction

endpackage

// File: rtl/mmio_uart_perf_if.sv
// CPU data-memory port as seen by the IO block: load/store strobes, address, data.
interface mmio_uart_perf_if;
  logic [31:0] addr;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, rd_en, wr_en, wdata, input rdata);
  modport slave  (input addr, rd_en, wr_en, wdata, output rdata);
endinterface

// File: rtl/mmio_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two.
module mmio_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: storage is not reset; pointers and count alone say which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: state updates use <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/uart.sv
// 8N1 UART with ready/valid byte ports; RX holds a finished byte until it is taken.
module uart #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic       serial_out,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready
);
  localparam int BIT_T = CLOCK_FREQ / BAUD_RATE;
  localparam int TW    = $clog2(BIT_T + 1);

  logic [9:0]    tx_sh;
  logic [3:0]    tx_bits;
  logic [TW-1:0] tx_t;

  assign data_in_ready = (tx_bits == 4'd0);
  assign serial_out    = tx_sh[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_sh   <= '1;
      tx_bits <= 4'd0;
      tx_t    <= '0;
    end else if (tx_bits == 4'd0) begin
      if (data_in_valid) begin
        tx_sh   <= {1'b1, data_in, 1'b0};
        tx_bits <= 4'd10;
        tx_t    <= '0;
      end
    end else if (tx_t == TW'(BIT_T - 1)) begin
      tx_t    <= '0;
      tx_sh   <= {1'b1, tx_sh[9:1]};
      tx_bits <= tx_bits - 4'd1;
    end else begin
      tx_t <= tx_t + TW'(1);
    end
  end

  logic [1:0]    rx_sync;
  logic [7:0]    rx_sh;
  logic [3:0]    rx_bits;
  logic [TW-1:0] rx_t;
  logic          rx_done;

  // A finished byte parks in rx_sh while data_out is occupied, so the receiver
  // stops listening instead of overrunning.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync        <= 2'b11;
      rx_sh          <= '0;
      rx_bits        <= 4'd0;
      rx_t           <= '0;
      rx_done        <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], serial_in};
      if (data_out_valid && data_out_ready) data_out_valid <= 1'b0;
      if (rx_done) begin
        if (!data_out_valid || data_out_ready) begin
          data_out       <= rx_sh;
          data_out_valid <= 1'b1;
          rx_done        <= 1'b0;
        end
      end else if (rx_bits == 4'd0) begin
        if (!rx_sync[1]) begin
          rx_bits <= 4'd10;
          rx_t    <= TW'(BIT_T / 2);
        end
      end else if (rx_t == '0) begin
        rx_t    <= TW'(BIT_T - 1);
        rx_bits <= rx_bits - 4'd1;
        if (rx_bits inside {[4'd2:4'd9]}) rx_sh <= {rx_sync[1], rx_sh[7:1]};
        if (rx_bits == 4'd1) rx_done <= 1'b1;
      end else begin
        rx_t <= rx_t - TW'(1);
      end
    end
  end
endmodule

// File: rtl/mmio_uart_perf.sv
// MMIO block: FIFO-buffered UART plus cycle/event counters behind BASE_ADDR.
// Define MMIO_SNAPSHOT_EN to add counter shadow registers loaded by a write to 0x3C.
module mmio_uart_perf
  import mmio_uart_perf_pkg::*;
#(
  parameter int          CPU_CLOCK_FREQ = 50_000_000,
  parameter int          BAUD_RATE      = 115_200,
  parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
  parameter int          RX_DEPTH       = 8,
  parameter int          TX_DEPTH       = 8,
  parameter int          NUM_EVT        = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               serial_in,
  output logic               serial_out,
  input  logic [NUM_EVT-1:0] evt_in,
  mmio_uart_perf_if.slave    bus
);
  localparam int RXC = $clog2(RX_DEPTH) + 1;
  localparam int TXC = $clog2(TX_DEPTH) + 1;

  logic       hit, rd_hit, wr_hit;
  logic [7:0] ofs;
  logic       unused_wdata;

  assign hit          = (bus.addr[31:8] == BASE_ADDR[31:8]);
  assign ofs          = bus.addr[7:0];
  assign rd_hit       = hit && bus.rd_en;
  assign wr_hit       = hit && bus.wr_en;
  assign unused_wdata = ^bus.wdata[31:8];

  logic           rx_full, rx_empty, rx_push, rx_pop;
  logic           tx_full, tx_empty, tx_push, tx_pop;
  logic [7:0]     rx_head, tx_head, uart_rx_data;
  logic           uart_rx_valid, uart_tx_ready;
  logic [RXC-1:0] rx_count;
  logic [TXC-1:0] tx_count;
  logic           tx_drop;

  assign rx_push = uart_rx_valid && !rx_full;
  assign rx_pop  = rd_hit && (ofs == OFS_RX) && !rx_empty;
  assign tx_push = wr_hit && (ofs == OFS_TX) && !tx_full;
  assign tx_pop  = uart_tx_ready && !tx_empty;

  mmio_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .wdata(uart_rx_data),
    .rdata(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  mmio_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .wdata(bus.wdata[7:0]),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  uart #(.CLOCK_FREQ(CPU_CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) u_uart (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_out(serial_out),
    .data_in(tx_head), .data_in_valid(!tx_empty), .data_in_ready(uart_tx_ready),
    .data_out(uart_rx_data), .data_out_valid(uart_rx_valid), .data_out_ready(!rx_full)
  );

  // A store to a full TX FIFO is lost even if the drain frees a slot that edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  tx_drop <= 1'b0;
    else if (wr_hit && (ofs == OFS_TX) && tx_full) tx_drop <= 1'b1;
    else if (rd_hit && (ofs == OFS_STATUS))    tx_drop <= 1'b0;
  end

  logic                    clr;
  logic [31:0]             cyc_cnt, cyc_rd;
  logic [NUM_EVT-1:0][31:0] evt_cnt, evt_rd;

  assign clr = wr_hit && (ofs == OFS_CLR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt <= '0;
      evt_cnt <= '0;
    end else if (clr) begin
      cyc_cnt <= '0;
      evt_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      for (int i = 0; i < NUM_EVT; i++) evt_cnt[i] <= evt_cnt[i] + 32'(evt_in[i]);
    end
  end

`ifdef MMIO_SNAPSHOT_EN
  logic                     snap;
  logic [31:0]              cyc_snap;
  logic [NUM_EVT-1:0][31:0] evt_snap;

  assign snap = wr_hit && (ofs == OFS_SNAP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_snap <= '0;
      evt_snap <= '0;
    end else if (snap) begin
      cyc_snap <= cyc_cnt;
      evt_snap <= evt_cnt;
    end
  end

  assign cyc_rd = cyc_snap;
  assign evt_rd = evt_snap;
`else
  assign cyc_rd = cyc_cnt;
  assign evt_rd = evt_cnt;
`endif

  logic [4:0]  status;
  logic [31:0] rdata;

  // NOTE: defaults first so every path assigns each output and no latch is inferred.
  always_comb begin
    status              = '0;
    status[ST_TX_READY] = !tx_full;
    status[ST_RX_VALID] = !rx_empty;
    status[ST_TX_DROP]  = tx_drop;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_RX_FULL]  = rx_full;

    rdata = '0;
    if (hit) begin
      case (ofs)
        OFS_STATUS: rdata = {27'b0, status};
        OFS_RX:     if (!rx_empty) rdata = {24'b0, rx_head};
        OFS_LVL:    rdata = {16'(tx_count), 16'(rx_count)};
        OFS_CYC:    rdata = cyc_rd;
        default:    ;
      endcase
      for (int i = 0; i < NUM_EVT; i++) begin
        if (ofs == evt_ofs(i)) rdata = evt_rd[i];
      end
    end
  end

  assign bus.rdata = rdata;
endmodule

// File: tb/tb_mmio_uart_perf.sv
// Scoreboard bench for mmio_uart_perf: reads push expected data, a negedge monitor compares.
module tb_mmio_uart_perf;
  import mmio_uart_perf_pkg::*;

  localparam logic [31:0] BASE    = 32'h8000_0000;
  localparam int          NUM_EVT = 3;
  localparam logic [7:0]  OFS_EVT2 = 8'h20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic loopback = 1'b1;
  logic tb_line = 1'b1;
  logic serial_in, serial_out;
  logic [NUM_EVT-1:0] evt_in = '0;

  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  mmio_uart_perf_if bus();

  assign serial_in = loopback ? serial_out : tb_line;
  always #5 clk = ~clk;

  // 10 clocks per bit keeps each UART frame at 100 cycles.
  mmio_uart_perf #(
    .CPU_CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .BASE_ADDR(BASE),
    .RX_DEPTH(8), .TX_DEPTH(8), .NUM_EVT(NUM_EVT)
  ) dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_out(serial_out),
    .evt_in(evt_in), .bus(bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] a(input logic [7:0] ofs);
    return BASE | {24'h0, ofs};
  endfunction

  task automatic bus_idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
    end
  endtask

  task automatic bus_rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    @(posedge clk); #1;
    bus.addr  = addr;
    bus.rd_en = 1'b1;
    bus.wr_en = 1'b0;
    exp_q.push_back(exp);
    name_q.push_back(name);
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    bus.addr  = addr;
    bus.wdata = data;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      tb_line = frame[i];
      repeat (10) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (bus.rd_en) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          check(name_q.pop_front(), bus.rdata, exp_q.pop_front());
        end
      end
    end
  end

  logic [7:0] rx_bytes [10] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89,
                                8'hAB, 8'hCD, 8'hEF, 8'h5A, 8'hA5};

  initial begin
    bus.addr = '0; bus.wdata = '0; bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    bus_idle(3);
    rst = 1'b1;

    // Reset in the middle of a transmitted start bit.
    bus_wr(a(OFS_TX), 32'h55);
    bus_idle(5);
    check("tx_start_bit", 32'(serial_out), 32'd0);
    rst = 1'b0;
    #1;
    check("reset_serial_out", 32'(serial_out), 32'd1);
    bus_rd(a(OFS_STATUS), 32'h09, "reset_status");
    bus_rd(a(OFS_LVL),    32'h0,  "reset_lvl");
    bus_rd(a(OFS_CYC),    32'h0,  "reset_cyc");
    bus_rd(a(OFS_EVT0),   32'h0,  "reset_evt0");
    bus_rd(a(OFS_EVT1),   32'h0,  "reset_evt1");
    bus_rd(a(OFS_EVT2),   32'h0,  "reset_evt2");
    bus_idle(1);
    rst = 1'b1;
    bus_idle(2);
    bus_rd(32'h8000_0100, 32'h0, "no_decode_match");

    // Loopback: the first byte goes straight into the transmitter, so two stay queued.
    bus_wr(a(OFS_TX), 32'h41);
    bus_wr(a(OFS_TX), 32'h42);
    bus_wr(a(OFS_TX), 32'h43);
    bus_rd(a(OFS_LVL), 32'h0002_0000, "lvl_tx_queued");
    bus_idle(400);
    bus_rd(a(OFS_LVL),    32'h0000_0003, "lvl_drained");
    bus_rd(a(OFS_STATUS), 32'h0B,        "status_rx_valid");
    bus_rd(a(OFS_RX),     32'h41,        "loop_byte0");
    bus_rd(a(OFS_RX),     32'h42,        "loop_byte1");
    bus_rd(a(OFS_RX),     32'h43,        "loop_byte2");
    bus_rd(a(OFS_STATUS), 32'h09,        "status_after_loop");

    // TX overflow while the transmitter is busy with a lead byte.
    bus_wr(a(OFS_TX), 32'h10);
    bus_idle(2);
    for (int i = 1; i <= 9; i++) bus_wr(a(OFS_TX), 32'h10 + 32'(i));
    bus_rd(a(OFS_LVL),    32'h0008_0000, "lvl_tx_full");
    bus_rd(a(OFS_STATUS), 32'h04,        "status_drop");
    bus_rd(a(OFS_STATUS), 32'h00,        "status_drop_cleared");
    bus_idle(1000);
    bus_rd(a(OFS_STATUS), 32'h1B, "status_rx_full_loop");
    for (int i = 0; i <= 8; i++) bus_rd(a(OFS_RX), 32'h10 + 32'(i), $sformatf("ovf_byte%0d", i));
    bus_rd(a(OFS_RX), 32'h0, "dropped_byte_absent");
    bus_idle(1);

    // RX back-pressure: ten injected bytes, eight in the FIFO and two held by the UART.
    loopback = 1'b0;
    for (int i = 0; i < 10; i++) send_byte(rx_bytes[i]);
    bus_idle(20);
    bus_rd(a(OFS_STATUS), 32'h1B,        "status_rx_full");
    bus_rd(a(OFS_LVL),    32'h0000_0008, "lvl_rx_full");
    for (int i = 0; i < 10; i++) bus_rd(a(OFS_RX), {24'h0, rx_bytes[i]}, $sformatf("rx_byte%0d", i));
    bus_rd(a(OFS_RX),     32'h0, "rx_empty_read");
    bus_rd(a(OFS_LVL),    32'h0, "lvl_no_pop");
    bus_rd(a(OFS_STATUS), 32'h09, "status_rx_drained");

    // Event counters and clear-wins-over-increment.
    bus_idle(1); evt_in = 3'b010;
    bus_idle(4);
    bus_rd(a(OFS_EVT1), 32'd5, "evt1_count"); evt_in = 3'b000;
    bus_wr(a(OFS_CLR), 32'h0);                evt_in = 3'b010;
    bus_rd(a(OFS_EVT1), 32'd0, "evt1_clear_wins"); evt_in = 3'b000;
    bus_rd(a(OFS_CYC),  32'd1, "cyc_after_clear");
    bus_idle(1); evt_in = 3'b101;
    bus_idle(2);
    bus_rd(a(OFS_EVT0), 32'd3, "evt0_count"); evt_in = 3'b000;
    bus_rd(a(OFS_EVT2), 32'd3, "evt2_count");

`ifdef MMIO_SNAPSHOT_EN
    bus_wr(a(OFS_CLR), 32'h0);
    bus_idle(9);
    bus_wr(a(OFS_SNAP), 32'h0);
    bus_idle(100);
    bus_rd(a(OFS_CYC),  32'd9, "snap_cyc_a");
    bus_rd(a(OFS_CYC),  32'd9, "snap_cyc_b");
    bus_rd(a(OFS_EVT2), 32'd0, "snap_evt2");
`else
    bus_wr(a(OFS_SNAP), 32'hFFFF_FFFF);
    bus_rd(a(OFS_SNAP), 32'h0, "snap_unmapped");
    bus_wr(a(OFS_CLR), 32'h0);
    bus_idle(100);
    bus_rd(a(OFS_CYC), 32'd100, "cyc_live_a");
    bus_rd(a(OFS_CYC), 32'd101, "cyc_live_b");
`endif

    bus_idle(2);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
